microwave_countdown: RTL
========================

Name: microwave_countdown

Overview:
- Downstream consumer of the seconds-tick counter stage.
- Takes that stage's level output as `tick_in` and counts one second per rising edge.
- Holds the cooking time as four BCD digits (MM:SS) and decrements it while cooking.
- Runs the cook/pause/alarm sequence that drives the magnetron enable and the display digits.

Parameters:
- ALARM_TICKS, 3, number of tick_in rising edges the alarm stays asserted before auto-return to IDLE (1..7).
- SEC_TENS_MAX, 5, largest legal seconds-tens digit; loaded values above it clamp to it.

Ports:
- clk  in  1  system clock.
- clear  in  1  synchronous reset, active-high.
- tick_in  in  1  level from the upstream tick counter; each 0->1 transition is one second.
- load  in  1  one-cycle pulse; captures the set_* digits.
- set_mt  in  4  minutes-tens BCD digit.
- set_mo  in  4  minutes-ones BCD digit.
- set_st  in  4  seconds-tens BCD digit.
- set_so  in  4  seconds-ones BCD digit.
- start  in  1  one-cycle pulse; begin or resume cooking.
- stop  in  1  one-cycle pulse; pause, or cancel when already paused.
- door_open  in  1  level; high means the door is open.
- mt, mo, st, so  out  4 each  current time digits.
- heating  out  1  magnetron enable; high only in RUNNING.
- alarm  out  1  high in ALARM.
- done  out  1  one-cycle pulse on entry to ALARM.

Behaviour:
- All state is registered on posedge clk.
- On clear: state=IDLE, digits=0, heating=0, alarm=0, done=0, tick edge-detect register=0, alarm counter=0.
- clear overrides every other input in the same cycle.
- Tick edge: tick_rise = tick_in & ~tick_q, where tick_q is tick_in delayed by one register. Only tick_rise is used internally.
- States:
  - IDLE: digits zero.
    - load -> LOADED.
    - start, stop and tick_rise are ignored.
  - LOADED: digits hold.
    - start & ~door_open & time!=0 -> RUNNING.
    - start with time==0 -> stays LOADED.
    - stop -> IDLE, digits cleared.
    - load -> re-captures digits.
  - RUNNING: heating=1.
    - Each tick_rise decrements MM:SS by one.
    - A decrement that reaches 00:00 moves to ALARM in the same edge, with done=1 for one cycle.
    - door_open or stop -> PAUSED. heating drops on the following clock edge.
    - load is ignored.
  - PAUSED: digits hold.
    - start & ~door_open -> RUNNING.
    - stop -> IDLE, digits cleared.
    - load -> LOADED with new digits.
  - ALARM: alarm=1, digits 00:00.
    - Counts tick_rise; after ALARM_TICKS edges -> IDLE.
    - stop -> IDLE immediately.
    - load -> LOADED.
- Priority within a cycle: clear > load (where accepted) > stop > door_open > start > tick_rise.
- If stop and tick_rise coincide in RUNNING, no decrement occurs.
- BCD decrement with borrow:
  - so 0->9 borrows from st.
  - st 0->SEC_TENS_MAX borrows from mo.
  - mo 0->9 borrows from mt.
  - 00:00 is never decremented.
- Load clamping:
  - Digits >9 are clamped to 9.
  - set_st > SEC_TENS_MAX is clamped to SEC_TENS_MAX.
  - Clamping happens at capture, so the outputs are always valid BCD.
- Load of 00:00 goes to LOADED with zero time; start is then ignored.
- Maximum time is 99:59; there is no wrap-around.
- clear mid-RUNNING: heating is 0 in the cycle after clear is sampled.

Decomposition:
- Shared package microwave_pkg holds:
  - state encoding constants (IDLE, LOADED, RUNNING, PAUSED, ALARM; 3 bits);
  - BCD_MAX=9;
  - the digit width constant (4).
- Sub-module bcd_digit_dec: one digit with inputs value, borrow_in and max, and outputs next value and borrow_out. Instantiated 4 times in a borrow chain.

Test Plan:
- clear, then load 00:03, start, 3 tick_in pulses -> digits 00:02, 00:01, 00:00; done pulses once on the third edge; alarm=1, heating=0.
- Load 01:00, start, one tick -> 00:59 (the seconds-tens borrow yields 5, not 9).
- Running at 00:10, door_open high for 2 ticks -> state PAUSED, digits still 00:10, heating=0; door closes then start -> RUNNING; next tick gives 00:09.
- Load digits 12,3,7,9 (mt, mo, st, so) -> outputs 9,3,5,9; load 00:00 then start -> stays LOADED, heating=0.
- In ALARM with ALARM_TICKS=3: 3 ticks -> IDLE, alarm=0. Separate run: stop in ALARM -> IDLE next cycle.
- tick_in held high for 20 cycles while RUNNING at 00:05 -> exactly one decrement, to 00:04. clear asserted mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave countdown block.
package microwave_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BCD_MAX = 9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOADED  = 3'd1,
        RUNNING = 3'd2,
        PAUSED  = 3'd3,
        ALARM   = 3'd4
    } state_e;

    // Cooking time as four BCD digits, MM:SS.
    typedef struct packed {
        logic [DIGIT_W-1:0] mt;
        logic [DIGIT_W-1:0] mo;
        logic [DIGIT_W-1:0] st;
        logic [DIGIT_W-1:0] so;
    } cook_time_t;

    // Saturate a captured digit to its legal maximum.
    function automatic logic [DIGIT_W-1:0] clamp_digit(
        input logic [DIGIT_W-1:0] d,
        input logic [DIGIT_W-1:0] lim
    );
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the countdown borrow chain.
module bcd_digit_dec
    import microwave_pkg::*;
(
    input  logic [DIGIT_W-1:0] value,
    input  logic               borrow_in,
    input  logic [DIGIT_W-1:0] max,
    output logic [DIGIT_W-1:0] next_value_c,
    output logic               borrow_out_c
);

    // Decrement on borrow; a zero digit wraps to its max and borrows upward.
    always_comb begin
        next_value_c = value;
        borrow_out_c = 1'b0;
        if (borrow_in) begin
            if (value == '0) begin
                next_value_c = max;
                borrow_out_c = 1'b1;
            end else begin
                next_value_c = value - DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/microwave_countdown.sv
// MM:SS cook timer: load/start/pause/alarm sequencing driven by a seconds tick.
module microwave_countdown
    import microwave_pkg::*;
#(
    parameter int unsigned ALARM_TICKS  = 3,
    parameter int unsigned SEC_TENS_MAX = 5
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               tick_in,
    input  logic               load,
    input  logic [DIGIT_W-1:0] set_mt,
    input  logic [DIGIT_W-1:0] set_mo,
    input  logic [DIGIT_W-1:0] set_st,
    input  logic [DIGIT_W-1:0] set_so,
    input  logic               start,
    input  logic               stop,
    input  logic               door_open,
    output logic [DIGIT_W-1:0] mt,
    output logic [DIGIT_W-1:0] mo,
    output logic [DIGIT_W-1:0] st,
    output logic [DIGIT_W-1:0] so,
    output logic               heating,
    output logic               alarm,
    output logic               done
);

    localparam int unsigned        CNT_W      = 3;
    localparam logic [DIGIT_W-1:0] DIG_MAX    = DIGIT_W'(BCD_MAX);
    localparam logic [DIGIT_W-1:0] ST_MAX     = DIGIT_W'(SEC_TENS_MAX);
    localparam logic [CNT_W-1:0]   ALARM_LAST = CNT_W'(ALARM_TICKS - 1);

    state_e           state_q, state_d;
    cook_time_t       time_q, time_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             heating_q, heating_d;
    logic             alarm_q, alarm_d;
    logic             done_q, done_d;

    logic             tick_rise_c;
    cook_time_t       load_val_c;
    cook_time_t       time_dec_c;
    logic [DIGIT_W-1:0] dec_mt_c, dec_mo_c, dec_st_c, dec_so_c;
    logic             b_so_c, b_st_c, b_mo_c, b_mt_c;
    logic             time_zero_c;

    assign tick_d      = tick_in;
    assign tick_rise_c = tick_in & ~tick_q;

    // Captured digits are clamped so the display never shows invalid BCD.
    assign load_val_c = '{
        mt: clamp_digit(set_mt, DIG_MAX),
        mo: clamp_digit(set_mo, DIG_MAX),
        st: clamp_digit(set_st, ST_MAX),
        so: clamp_digit(set_so, DIG_MAX)
    };

    // Borrow chain; a borrow out of the minutes-tens digit means the time is 00:00.
    bcd_digit_dec u_dec_so (
        .value(time_q.so), .borrow_in(1'b1),   .max(DIG_MAX),
        .next_value_c(dec_so_c), .borrow_out_c(b_so_c)
    );
    bcd_digit_dec u_dec_st (
        .value(time_q.st), .borrow_in(b_so_c), .max(ST_MAX),
        .next_value_c(dec_st_c), .borrow_out_c(b_st_c)
    );
    bcd_digit_dec u_dec_mo (
        .value(time_q.mo), .borrow_in(b_st_c), .max(DIG_MAX),
        .next_value_c(dec_mo_c), .borrow_out_c(b_mo_c)
    );
    bcd_digit_dec u_dec_mt (
        .value(time_q.mt), .borrow_in(b_mo_c), .max(DIG_MAX),
        .next_value_c(dec_mt_c), .borrow_out_c(b_mt_c)
    );

    assign time_dec_c  = '{mt: dec_mt_c, mo: dec_mo_c, st: dec_st_c, so: dec_so_c};
    assign time_zero_c = b_mt_c;

    // Next-state, digit and output logic; branch order encodes input priority.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        cnt_d   = '0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                time_d = '0;
                if (load) begin
                    state_d = LOADED;
                    time_d  = load_val_c;
                end
            end
            LOADED: begin
                if (load) begin
                    time_d = load_val_c;
                end else if (stop) begin
                    state_d = IDLE;
                    time_d  = '0;
                end else if (start && !door_open && !time_zero_c) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                if (stop || door_open) begin
                    state_d = PAUSED;
                end else if (tick_rise_c && !time_zero_c) begin
                    time_d = time_dec_c;
                    if (time_dec_c == '0) begin
                        state_d = ALARM;
                        done_d  = 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (load) begin
                    state_d = LOADED;
                    time_d  = load_val_c;
                end else if (stop) begin
                    state_d = IDLE;
                    time_d  = '0;
                end else if (start && !door_open) begin
                    state_d = RUNNING;
                end
            end
            ALARM: begin
                time_d = '0;
                cnt_d  = cnt_q;
                if (load) begin
                    state_d = LOADED;
                    time_d  = load_val_c;
                    cnt_d   = '0;
                end else if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick_rise_c) begin
                    if (cnt_q == ALARM_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                time_d  = '0;
            end
        endcase
        heating_d = (state_d == RUNNING);
        alarm_d   = (state_d == ALARM);
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= IDLE;
            time_q    <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            heating_q <= 1'b0;
            alarm_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            heating_q <= heating_d;
            alarm_q   <= alarm_d;
            done_q    <= done_d;
        end
    end

    assign mt      = time_q.mt;
    assign mo      = time_q.mo;
    assign st      = time_q.st;
    assign so      = time_q.so;
    assign heating = heating_q;
    assign alarm   = alarm_q;
    assign done    = done_q;

endmodule
